// File: rtl/spike_decoder.sv
// spike_decoder: counts spike rising edges over a programmable window, publishes
// the count as RATE, regenerates a thresholded bit, and measures the
// inter-spike interval. Software access is through a 4-bit address / 8-bit data
// register port.
module spike_decoder #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_WINDOW = 4'h1;
  localparam logic [3:0] A_THRESH = 4'h2;
  localparam logic [3:0] A_RATE   = 4'h3;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_ISI_LO = 4'h5;
  localparam logic [3:0] A_ISI_HI = 4'h6;
  localparam logic [3:0] A_COUNT  = 4'h7;

  // spike input path
  logic s1_q, s2_q, s3_q, pulse_q;
  logic pulse;

  // configuration
  logic       en_q, en_d;
  logic [7:0] window_q, window_d;
  logic [7:0] thresh_q, thresh_d;

  // window machinery
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tick_q, tick_d;
  logic [7:0]    count_q, count_d;

  // published results
  logic [7:0]  rate_q, rate_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        dec_q, dec_d;

  // interval measurement
  logic [15:0] isi_cnt_q, isi_cnt_d;
  logic [15:0] isi_q, isi_d;
  logic        armed_q, armed_d;

  logic       wr_ctrl, wr_win, wr_thr, wr_stat, clr;
  logic       tick, win_end;
  logic [7:0] count_inc;

  // bits 7:1 of ui_in carry nothing for this block
  logic unused_ui;
  assign unused_ui = &{1'b0, ui_in[7:1]};

  assign wr_ctrl = data_write && (address == A_CTRL);
  assign wr_win  = data_write && (address == A_WINDOW);
  assign wr_thr  = data_write && (address == A_THRESH);
  assign wr_stat = data_write && (address == A_STATUS);
  assign clr     = wr_ctrl && data_in[1];

  assign pulse     = s2_q & ~s3_q;
  assign tick      = en_q && (presc_q == PRE_LAST);
  // window length 0 encodes 256: the 8-bit subtract wraps 0 to 255
  assign win_end   = tick && (tick_q == (window_q - 8'd1)) && !wr_win;
  assign count_inc = (pulse && en_q && count_q != 8'hFF) ? count_q + 8'd1 : count_q;

  // synchronizer, edge-detect delay and registered pulse for uo_out[2]
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= ui_in[0];
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= pulse;
    end
  end

  // next-state for config, window, result and interval registers
  always_comb begin
    en_d      = en_q;
    window_d  = window_q;
    thresh_d  = thresh_q;
    presc_d   = presc_q;
    tick_d    = tick_q;
    count_d   = count_q;
    rate_d    = rate_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    dec_d     = dec_q;
    isi_cnt_d = isi_cnt_q;
    isi_d     = isi_q;
    armed_d   = armed_q;

    if (wr_ctrl) en_d     = data_in[0];
    if (wr_win)  window_d = data_in;
    if (wr_thr)  thresh_d = data_in;

    // write-1-to-clear first so a same-cycle set below wins
    if (wr_stat) begin
      valid_d = valid_q & ~data_in[0];
      ovf_d   = ovf_q & ~data_in[1];
    end

    if (en_q) begin
      presc_d   = tick ? '0 : presc_q + PW'(1);
      if (tick) tick_d = win_end ? 8'd0 : tick_q + 8'd1;
      count_d   = count_inc;
      isi_cnt_d = (isi_cnt_q == 16'hFFFF) ? isi_cnt_q : isi_cnt_q + 16'd1;
      if (pulse) begin
        if (armed_q) isi_d = isi_cnt_q;
        isi_cnt_d = 16'd1;
        armed_d   = 1'b1;
      end
      if (win_end) begin
        rate_d  = count_inc;
        count_d = 8'd0;
        valid_d = 1'b1;
        dec_d   = (count_inc >= thresh_q);
        if (count_inc == 8'hFF) ovf_d = 1'b1;
      end
    end else begin
      presc_d   = '0;
      tick_d    = 8'd0;
      count_d   = 8'd0;
      isi_cnt_d = 16'd0;
      armed_d   = 1'b0;
    end

    // window restart drops the partial window, including a same-cycle pulse
    if (wr_win) begin
      presc_d = '0;
      tick_d  = 8'd0;
      count_d = 8'd0;
    end

    if (clr) begin
      presc_d   = '0;
      tick_d    = 8'd0;
      count_d   = 8'd0;
      isi_cnt_d = 16'd0;
      isi_d     = 16'd0;
      armed_d   = 1'b0;
      rate_d    = 8'd0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      dec_d     = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      window_q  <= 8'd0;
      thresh_q  <= 8'd0;
      presc_q   <= '0;
      tick_q    <= 8'd0;
      count_q   <= 8'd0;
      rate_q    <= 8'd0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      dec_q     <= 1'b0;
      isi_cnt_q <= 16'd0;
      isi_q     <= 16'd0;
      armed_q   <= 1'b0;
    end else begin
      en_q      <= en_d;
      window_q  <= window_d;
      thresh_q  <= thresh_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      dec_q     <= dec_d;
      isi_cnt_q <= isi_cnt_d;
      isi_q     <= isi_d;
      armed_q   <= armed_d;
    end
  end

  // combinational register read mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      A_CTRL:   data_out = {7'd0, en_q};
      A_WINDOW: data_out = window_q;
      A_THRESH: data_out = thresh_q;
      A_RATE:   data_out = rate_q;
      A_STATUS: data_out = {6'd0, ovf_q, valid_q};
      A_ISI_LO: data_out = isi_q[7:0];
      A_ISI_HI: data_out = isi_q[15:8];
      A_COUNT:  data_out = count_q;
      default:  data_out = 8'h00;
    endcase
  end

  assign uo_out = {5'd0, pulse_q, valid_q, dec_q};

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench for spike_decoder: register table plus hand-timed sequences
// for window end, interval, saturation, restart and reset corner cases.
module tb_spike_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  spike_decoder #(.PRESCALE(16)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_write(data_write), .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic spike(input int hi, input int lo);
    ui_in = 8'h01;
    cyc(hi);
    ui_in = 8'h00;
    cyc(lo);
  endtask

  task automatic rchk(input string nm, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(nm, {8'd0, v}, {8'd0, exp});
  endtask

  initial begin
    logic [7:0] v;

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 4'(i), 8'h00, 8'h00};
    tbl[16] = '{1'b1, 4'h1, 8'h5A, 8'h5A};  // WINDOW rw
    tbl[17] = '{1'b1, 4'h2, 8'hC3, 8'hC3};  // THRESH rw
    tbl[18] = '{1'b1, 4'h0, 8'h03, 8'h01};  // clear bit reads 0
    tbl[19] = '{1'b1, 4'h3, 8'h77, 8'h00};  // RATE read-only
    tbl[20] = '{1'b1, 4'h7, 8'h11, 8'h00};  // COUNT read-only
    tbl[21] = '{1'b1, 4'h5, 8'h22, 8'h00};  // ISI_LO read-only
    tbl[22] = '{1'b1, 4'h9, 8'hFF, 8'h00};  // unmapped
    tbl[23] = '{1'b1, 4'h4, 8'hFF, 8'h00};  // STATUS w1c on zero

    rst = 1'b1; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    cyc(3);
    rst = 1'b0;
    chk("reset_uo_out", {8'd0, uo_out}, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, v);
      chk($sformatf("table[%0d] addr%0h", i, tbl[i].addr), {8'd0, v}, {8'd0, tbl[i].exp});
    end

    // empty 256-tick window
    wr(4'h0, 8'h02);
    wr(4'h1, 8'h00);
    wr(4'h0, 8'h01);
    cyc(4100);
    rchk("w256_rate", 4'h3, 8'h00);
    rchk("w256_status", 4'h4, 8'h01);
    chk("w256_uo", {8'd0, uo_out}, 16'h0002);

    // 10 spikes, period 6, in a 64-clock window
    wr(4'h0, 8'h02);
    wr(4'h1, 8'h04);
    wr(4'h2, 8'h08);
    wr(4'h0, 8'h01);
    for (int i = 0; i < 10; i++) spike(2, 4);
    cyc(6);
    rchk("rate10", 4'h3, 8'h0A);
    rchk("isi_lo6", 4'h5, 8'h06);
    rchk("isi_hi6", 4'h6, 8'h00);
    rchk("status10", 4'h4, 8'h01);
    chk("uo10", {8'd0, uo_out}, 16'h0003);

    // 5 spikes: below threshold, then clear valid
    wr(4'h0, 8'h00);
    wr(4'h0, 8'h01);
    for (int i = 0; i < 5; i++) spike(2, 4);
    cyc(36);
    rchk("rate5", 4'h3, 8'h05);
    chk("uo5", {8'd0, uo_out}, 16'h0002);
    wr(4'h4, 8'h01);
    rchk("status_w1c", 4'h4, 8'h00);
    chk("uo_w1c", {8'd0, uo_out}, 16'h0000);

    // long high: one pulse, latency, then ISI of 300
    wr(4'h0, 8'h02);
    wr(4'h1, 8'h00);
    wr(4'h0, 8'h01);
    ui_in = 8'h01;
    cyc(2);
    rchk("lat_count_early", 4'h7, 8'h00);
    chk("lat_pulse_early", {15'd0, uo_out[2]}, 16'h0000);
    cyc(1);
    rchk("lat_count", 4'h7, 8'h01);
    chk("lat_pulse", {15'd0, uo_out[2]}, 16'h0001);
    cyc(1);
    chk("lat_pulse_end", {15'd0, uo_out[2]}, 16'h0000);
    cyc(196);
    ui_in = 8'h00;
    rchk("long_high_count", 4'h7, 8'h01);
    cyc(100);
    spike(2, 4);
    rchk("isi300_lo", 4'h5, 8'h2C);
    rchk("isi300_hi", 4'h6, 8'h01);
    rchk("count2", 4'h7, 8'h02);

    // saturation over a 255-tick window
    wr(4'h0, 8'h02);
    wr(4'h1, 8'hFF);
    wr(4'h0, 8'h01);
    for (int i = 0; i < 1021; i++) begin
      spike(2, 2);
      if (i == 400) rchk("sat_count", 4'h7, 8'hFF);
    end
    rchk("sat_rate", 4'h3, 8'hFF);
    rchk("sat_status", 4'h4, 8'h03);
    chk("sat_dec", {15'd0, uo_out[0]}, 16'h0001);
    wr(4'h4, 8'h03);
    rchk("sat_status_clr", 4'h4, 8'h00);

    // WINDOW write in the window-end cycle suppresses it and restarts
    wr(4'h0, 8'h02);
    wr(4'h1, 8'h04);
    wr(4'h0, 8'h01);
    cyc(63);
    wr(4'h1, 8'h04);
    rchk("suppress_status", 4'h4, 8'h00);
    cyc(63);
    rchk("restart_early", 4'h4, 8'h00);
    cyc(1);
    rchk("restart_end", 4'h4, 8'h01);

    // pulse on the window-end cycle counts in the closing RATE
    wr(4'h0, 8'h02);
    wr(4'h0, 8'h01);
    spike(2, 4);
    spike(2, 4);
    cyc(49);
    ui_in = 8'h01;
    cyc(2);
    ui_in = 8'h00;
    cyc(4);
    rchk("edge_rate", 4'h3, 8'h03);
    rchk("edge_count", 4'h7, 8'h00);
    rchk("edge_status", 4'h4, 8'h01);

    // reset mid-window
    wr(4'h0, 8'h02);
    wr(4'h0, 8'h01);
    for (int i = 0; i < 3; i++) spike(2, 4);
    rchk("pre_rst_count", 4'h7, 8'h03);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) rchk($sformatf("rst_addr%0d", a), 4'(a), 8'h00);
    chk("rst_uo", {8'd0, uo_out}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
